// File: rtl/nios2_cpu_div_cell_if.sv
// rtl/nios2_cpu_div_cell_if.sv - operand/result bundle between pipeline and divider (div_remainder only with NIOS2_DIV_REMAINDER_EN)
interface nios2_cpu_div_cell_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] E_src1;
    logic [WIDTH-1:0] E_src2;
    logic             E_div_start;
    logic             E_div_signed;
    logic             M_div_abort;
    logic             div_busy;
    logic             div_valid;
    logic [WIDTH-1:0] div_quotient;
    logic             div_by_zero;
`ifdef NIOS2_DIV_REMAINDER_EN
    logic [WIDTH-1:0] div_remainder;
`endif

    // Pipeline side: issues operations and consumes results
    modport master (
        output E_src1, E_src2, E_div_start, E_div_signed, M_div_abort,
`ifdef NIOS2_DIV_REMAINDER_EN
        input  div_remainder,
`endif
        input  div_busy, div_valid, div_quotient, div_by_zero
    );

    // Divider side
    modport slave (
        input  E_src1, E_src2, E_div_start, E_div_signed, M_div_abort,
`ifdef NIOS2_DIV_REMAINDER_EN
        output div_remainder,
`endif
        output div_busy, div_valid, div_quotient, div_by_zero
    );
endinterface

// File: rtl/nios2_cpu_div_cell.sv
// rtl/nios2_cpu_div_cell.sv - iterative radix-2 restoring divider; optional remainder port via NIOS2_DIV_REMAINDER_EN
module nios2_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios2_cpu_div_cell_if.slave    bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic [WIDTH-1:0] quo_q,      quo_d;
    logic [WIDTH-1:0] dvs_q,      dvs_d;
    logic             sign1_q,    sign1_d;
    logic             sign2_q,    sign2_d;
    logic             dz_q,       dz_d;
    logic             valid_q,    valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic             by_zero_q,  by_zero_d;
`ifdef NIOS2_DIV_REMAINDER_EN
    logic [WIDTH-1:0] remainder_q, remainder_d;
`endif

    // {rem,quo} shifted left by one; the dividend bit entering rem is quo's MSB
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Trial subtraction; diff[WIDTH] set means the divisor did not fit
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    // Next-state and datapath: capture magnitudes, iterate, then sign-correct
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        dz_d       = dz_q;
        valid_d    = 1'b0;
        quotient_d = quotient_q;
        by_zero_d  = by_zero_q;
`ifdef NIOS2_DIV_REMAINDER_EN
        remainder_d = remainder_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.E_div_start && !bus.M_div_abort) begin
                    sign1_d = bus.E_div_signed & bus.E_src1[WIDTH-1];
                    sign2_d = bus.E_div_signed & bus.E_src2[WIDTH-1];
                    quo_d   = sign1_d ? -bus.E_src1 : bus.E_src1;
                    dvs_d   = sign2_d ? -bus.E_src2 : bus.E_src2;
                    dz_d    = (bus.E_src2 == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d   = S_IDLE;
                valid_d   = 1'b1;
                by_zero_d = dz_q;
                // A zero divisor leaves the dividend magnitude in rem, so the
                // normal remainder sign rule already restores the dividend.
                if (dz_q) begin
                    quotient_d = '1;
                end else begin
                    quotient_d = (sign1_q ^ sign2_q) ? -quo_q : quo_q;
                end
`ifdef NIOS2_DIV_REMAINDER_EN
                remainder_d = sign1_q ? -rem_q : rem_q;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush cancels an in-flight operation and suppresses its result
        if (bus.M_div_abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            valid_d    = 1'b0;
            quotient_d = quotient_q;
            by_zero_d  = by_zero_q;
`ifdef NIOS2_DIV_REMAINDER_EN
            remainder_d = remainder_q;
`endif
        end
    end

    // State and result registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            dz_q       <= 1'b0;
            valid_q    <= 1'b0;
            quotient_q <= '0;
            by_zero_q  <= 1'b0;
`ifdef NIOS2_DIV_REMAINDER_EN
            remainder_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            dz_q       <= dz_d;
            valid_q    <= valid_d;
            quotient_q <= quotient_d;
            by_zero_q  <= by_zero_d;
`ifdef NIOS2_DIV_REMAINDER_EN
            remainder_q <= remainder_d;
`endif
        end
    end

    assign bus.div_busy     = (state_q != S_IDLE);
    assign bus.div_valid    = valid_q;
    assign bus.div_quotient = quotient_q;
    assign bus.div_by_zero  = by_zero_q;
`ifdef NIOS2_DIV_REMAINDER_EN
    assign bus.div_remainder = remainder_q;
`endif

endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// tb/tb_nios2_cpu_div_cell.sv - directed self-checking bench for nios2_cpu_div_cell
module tb_nios2_cpu_div_cell;
    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    nios2_cpu_div_cell_if #(.WIDTH(32)) bus ();

    nios2_cpu_div_cell #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the first negedge after the accepting edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.E_src1       = a;
        bus.E_src2       = b;
        bus.E_div_signed = s;
        bus.E_div_start  = 1'b1;
        @(negedge clk);
        bus.E_div_start  = 1'b0;
    endtask

    // Returns in the div_valid cycle (or after the cycle budget runs out)
    task automatic wait_result(input string tag, input int lat0, input logic [31:0] eq,
                               input logic [31:0] er, input logic edz);
        int lat;
        int gaps;
        lat  = lat0;
        gaps = 0;
        while (bus.div_valid !== 1'b1 && lat < 40) begin
            if (bus.div_busy !== 1'b1) gaps++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".latency"}, lat, 34);
        check_eq({tag, ".busy_gaps"}, gaps, 0);
        check_eq({tag, ".busy_at_valid"}, bus.div_busy, 1'b0);
        check_eq({tag, ".quotient"}, bus.div_quotient, eq);
        check_eq({tag, ".by_zero"}, bus.div_by_zero, edz);
`ifdef NIOS2_DIV_REMAINDER_EN
        check_eq({tag, ".remainder"}, bus.div_remainder, er);
`else
        if (er === 32'hx) $display("unexpected unknown remainder expectation in %s", tag);
`endif
    endtask

    task automatic count_valids(input string tag, input int cycles);
        int v;
        int b;
        v = 0;
        b = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.div_valid === 1'b1) v++;
            if (bus.div_busy === 1'b1) b++;
        end
        check_eq({tag, ".no_valid"}, v, 0);
        check_eq({tag, ".no_busy"}, b, 0);
    endtask

    initial begin
        clk              = 1'b0;
        reset_n          = 1'b0;
        tests_run        = 0;
        tests_failed     = 0;
        bus.E_src1       = '0;
        bus.E_src2       = '0;
        bus.E_div_start  = 1'b0;
        bus.E_div_signed = 1'b0;
        bus.M_div_abort  = 1'b0;

        #3;
        check_eq("reset.busy", bus.div_busy, 1'b0);
        check_eq("reset.valid", bus.div_valid, 1'b0);
        check_eq("reset.quotient", bus.div_quotient, 32'h0);
        check_eq("reset.by_zero", bus.div_by_zero, 1'b0);
`ifdef NIOS2_DIV_REMAINDER_EN
        check_eq("reset.remainder", bus.div_remainder, 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Unsigned 100 / 7, plus one-cycle valid pulse
        @(negedge clk);
        issue(32'd100, 32'd7, 1'b0);
        wait_result("divu_100_7", 1, 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        check_eq("divu_100_7.pulse", bus.div_valid, 1'b0);
        check_eq("divu_100_7.hold", bus.div_quotient, 32'd14);

        // Signed cases
        @(negedge clk);
        issue(32'hFFFFFF9C, 32'd7, 1'b1);
        wait_result("div_m100_7", 1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        @(negedge clk);
        issue(32'd7, 32'hFFFFFFFE, 1'b1);
        wait_result("div_7_m2", 1, 32'hFFFFFFFD, 32'd1, 1'b0);

        // Overflow, signed and unsigned
        @(negedge clk);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_result("div_ovf", 1, 32'h80000000, 32'h0, 1'b0);
        @(negedge clk);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_result("divu_ovf", 1, 32'h0, 32'h80000000, 1'b0);

        // Large unsigned dividend
        @(negedge clk);
        issue(32'hFFFFFFFF, 32'h10, 1'b0);
        wait_result("divu_big", 1, 32'h0FFFFFFF, 32'hF, 1'b0);

        // Start while busy is ignored
        @(negedge clk);
        issue(32'd1000, 32'd3, 1'b0);
        bus.E_src1      = 32'd50;
        bus.E_src2      = 32'd5;
        bus.E_div_start = 1'b1;
        @(negedge clk);
        bus.E_div_start = 1'b0;
        wait_result("busy_ignore", 2, 32'd333, 32'd1, 1'b0);

        // Abort at iteration 10 keeps the previous quotient
        @(negedge clk);
        issue(32'h0000FFFF, 32'h10, 1'b0);
        repeat (10) @(negedge clk);
        bus.M_div_abort = 1'b1;
        @(negedge clk);
        bus.M_div_abort = 1'b0;
        check_eq("abort.busy", bus.div_busy, 1'b0);
        check_eq("abort.valid", bus.div_valid, 1'b0);
        check_eq("abort.quotient", bus.div_quotient, 32'd333);
        count_valids("abort", 40);

        // Abort beats start in the same cycle
        bus.E_src1      = 32'd9;
        bus.E_src2      = 32'd3;
        bus.E_div_start = 1'b1;
        bus.M_div_abort = 1'b1;
        @(negedge clk);
        bus.E_div_start = 1'b0;
        bus.M_div_abort = 1'b0;
        check_eq("abort_prio.busy", bus.div_busy, 1'b0);
        count_valids("abort_prio", 36);

        // Back-to-back start in the valid cycle
        @(negedge clk);
        issue(32'd200, 32'd9, 1'b0);
        wait_result("b2b_first", 1, 32'd22, 32'd2, 1'b0);
        issue(32'd81, 32'd9, 1'b0);
        wait_result("b2b_second", 1, 32'd9, 32'd0, 1'b0);

        // Zero divisor
        @(negedge clk);
        issue(32'h12345678, 32'h0, 1'b1);
        wait_result("div_zero", 1, 32'hFFFFFFFF, 32'h12345678, 1'b1);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        issue(32'hFFFFFFFF, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid.busy", bus.div_busy, 1'b0);
        check_eq("rst_mid.valid", bus.div_valid, 1'b0);
        check_eq("rst_mid.quotient", bus.div_quotient, 32'h0);
        check_eq("rst_mid.by_zero", bus.div_by_zero, 1'b0);
`ifdef NIOS2_DIV_REMAINDER_EN
        check_eq("rst_mid.remainder", bus.div_remainder, 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        count_valids("rst_mid", 40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/nios2_cpu_div_cell.md
Name: nios2_cpu_div_cell

Overview:
- Iterative radix-2 restoring divider for the Nios II custom core execute/memory pipeline.
- It is the inverse-operation companion to the partial-product multiplier cell.
- It accepts two operands plus a start pulse and computes quotient and remainder, signed or unsigned, over WIDTH+2 cycles.
- It returns the result with a one-cycle valid pulse and holds busy while computing, so the pipeline control stalls on div/divu.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 4.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- E_src1  input  WIDTH  dividend; sampled on the edge where a start is accepted.
- E_src2  input  WIDTH  divisor; sampled with E_src1.
- E_div_start  input  1  start request; accepted only when div_busy=0.
- E_div_signed  input  1  1=div (two's complement), 0=divu; sampled with operands.
- M_div_abort  input  1  pipeline flush; cancels any operation in progress.
- div_busy  output  1  high while an accepted operation is in CALC or FIXUP.
- div_valid  output  1  one-cycle pulse; div_quotient (and div_remainder) valid in that cycle.
- div_quotient  output  WIDTH  registered quotient; holds until the next completion.
- div_by_zero  output  1  registered with div_valid; 1 if the divisor was 0.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, div_busy=0, div_valid=0, div_quotient=0, div_by_zero=0, internal counter and registers=0.
- States: IDLE, CALC, FIXUP.
  - IDLE to CALC: on an edge with E_div_start=1.
  - CALC to FIXUP: after WIDTH iterations.
  - FIXUP to IDLE: always, after one edge.
- On start acceptance, capture sign flags and magnitudes:
  - If signed and operand MSB=1, store its two's-complement negation; otherwise store it as-is.
  - Clear the partial remainder and set the iteration counter to 0.
- CALC, one iteration per edge, MSB first:
  - Shift {rem,quo} left by 1.
  - Trial subtract: rem - divisor_mag, computed at WIDTH+1 bits.
  - If non-negative: rem takes the difference and quo LSB=1. Otherwise rem is unchanged and quo LSB=0.
  - The counter increments; after the iteration with counter=WIDTH-1, go to FIXUP.
- FIXUP edge: apply sign correction and register the outputs; div_valid=1 for exactly that following cycle.
  - Quotient is negated if signed and sign1 != sign2.
  - Remainder is negated if signed and sign1=1.
- Latency: div_valid is high in the cycle after the (WIDTH+2)th rising edge counted from the edge that accepted the start (34 for WIDTH=32).
- div_busy: 1 from the edge after acceptance until the FIXUP edge; it is 0 in the div_valid cycle. A back-to-back start in the div_valid cycle is accepted.
- E_div_start while div_busy=1: ignored; no queuing.
- Divide by zero (divisor=0, either mode):
  - quotient = all ones, remainder = original dividend (unsigned bit pattern), div_by_zero=1.
  - Full latency still applies; there is no trap.
- Signed overflow (dividend = minimum negative, divisor = -1): quotient = 0x80000000 (wraps), remainder = 0, div_by_zero=0.
- M_div_abort=1: the next edge forces IDLE and div_busy=0, with no div_valid. div_quotient keeps its previous value.
  - Abort takes priority over start in the same cycle.
  - Abort while IDLE has no effect.
- Reset mid-operation: immediate return to the reset values; no valid pulse.

Optional Feature:
- Macro NIOS2_DIV_REMAINDER_EN.
- Defined: adds output port div_remainder [WIDTH-1:0], registered at the FIXUP edge with the sign rules above; reset value 0. This supports the remainder idiom without a multiply-back.
- Undefined: no port, and the final remainder correction logic is removed. Quotient, latency and all flags are identical.

Test Plan:
- Unsigned: start with E_src1=100, E_src2=7, signed=0 -> div_valid exactly 34 edges later; quotient=14, remainder=2, div_by_zero=0; div_busy high for the 33 cycles before.
- Signed: E_src1=-100 (0xFFFFFF9C), E_src2=7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); repeat with 7 / -2 -> quotient=-3, remainder=1.
- Zero divisor: E_src1=0x12345678, E_src2=0, signed=1 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, at the normal latency.
- Overflow: E_src1=0x80000000, E_src2=0xFFFFFFFF, signed=1 -> quotient=0x80000000, remainder=0; divu of the same operands -> quotient=0, remainder=0x80000000.
- Control:
  - Start during busy is ignored (result matches the first operands).
  - M_div_abort at iteration 10 -> no div_valid, div_busy=0 next cycle, quotient unchanged.
  - A new start in the div_valid cycle completes 34 edges later.
- Reset: pulse reset_n low mid-CALC -> all outputs 0 immediately (asynchronously); no spurious div_valid after release.
